usb_tx_encoder: RTL and testbench

//  USB full-speed packet transmitter; executes the tx_packet command issued by the protocol controller.

---
 rtl/usb_pkg.sv | 36 +++
 rtl/usb_crc16_serial.sv | 21 ++
 rtl/usb_tx_encoder.sv | 183 ++++++++++++++++++
 tb/tb_usb_tx_encoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_pkg.sv
// Shared encodings, PID/SYNC constants, CRC16 parameters and encoder state enum
// for the USB full-speed transmit path.
package usb_pkg;

    localparam logic [1:0] TX_IDLE   = 2'b00;
    localparam logic [1:0] SEND_DATA = 2'b01;
    localparam logic [1:0] SEND_ACK  = 2'b10;
    localparam logic [1:0] SEND_NACK = 2'b11;

    localparam logic [7:0] PID_ACK   = 8'hD2;
    localparam logic [7:0] PID_NACK  = 8'h5A;
    localparam logic [7:0] PID_DATA0 = 8'hC3;
    localparam logic [7:0] PID_DATA1 = 8'h4B;

    localparam logic [7:0]  SYNC_BYTE       = 8'h80;
    localparam logic [15:0] CRC16_POLY_REFL = 16'hA001;
    localparam logic [15:0] CRC16_INIT      = 16'hFFFF;
    localparam logic [6:0]  MAX_PAYLOAD     = 7'd64;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SYNC,
        ST_PID,
        ST_DATA,
        ST_CRC,
        ST_EOP_SE0,
        ST_EOP_J,
        ST_DONE
    } tx_state_e;

    // One LSB-first step of the reflected CRC16 register.
    function automatic logic [15:0] crc16_step(input logic [15:0] crc, input logic b);
        crc16_step = (crc >> 1) ^ ((crc[0] ^ b) ? CRC16_POLY_REFL : 16'h0000);
    endfunction

endpackage

// File: rtl/usb_crc16_serial.sv
// Bit-serial CRC16 over payload bits; clr re-seeds, en advances one bit.
module usb_crc16_serial
    import usb_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        bit_in,
    output logic [15:0] crc
);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= CRC16_INIT;
        end else if (en) begin
            crc <= crc16_step(crc, bit_in);
        end
    end

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed packet transmitter: SYNC, PID, payload, CRC16, EOP with stuffing and NRZI.
// Optional DATA0/DATA1 alternation is enabled by defining USB_TX_DATA_TOGGLE_EN.
module usb_tx_encoder
    import usb_pkg::*;
#(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] tx_packet,
    input  logic [6:0] buffer_occupancy,
    input  logic [7:0] tx_packet_data,
    output logic       get_tx_packet_data,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_status,
    output logic       tx_busy
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CLK_LAST = CW'(CLKS_PER_BIT - 1);

    tx_state_e     state, state_n;
    logic [CW-1:0] clk_cnt;
    logic [3:0]    bit_idx;
    logic [7:0]    shifter;
    logic [6:0]    byte_cnt;
    logic [1:0]    cmd;
    logic [2:0]    ones;
    logic          stuff;
    logic          lvl;
    logic [15:0]   crc;
    logic [7:0]    data_pid;
    logic [7:0]    pid_byte;

    logic bit_end, serial, stuff_ok, cur_bit, last, stuff_due, adv;
    logic line_j, se0, crc_clr, crc_en, pop;

`ifdef USB_TX_DATA_TOGGLE_EN
    logic toggle;
    always_ff @(posedge clk) begin
        if (rst) begin
            toggle <= 1'b0;
        end else if (state == ST_DONE && cmd == SEND_DATA) begin
            toggle <= ~toggle;
        end
    end
    assign data_pid = toggle ? PID_DATA1 : PID_DATA0;
`else
    assign data_pid = PID_DATA0;
`endif

    always_comb begin
        case (cmd)
            SEND_ACK:  pid_byte = PID_ACK;
            SEND_NACK: pid_byte = PID_NACK;
            default:   pid_byte = data_pid;
        endcase
    end

    assign bit_end  = (clk_cnt == CLK_LAST);
    assign serial   = state inside {ST_SYNC, ST_PID, ST_DATA, ST_CRC};
    assign stuff_ok = state inside {ST_PID, ST_DATA, ST_CRC};
    // The CRC is sent straight from the (frozen) CRC register, complemented.
    assign cur_bit  = stuff ? 1'b0 : ((state == ST_CRC) ? ~crc[bit_idx] : shifter[0]);
    assign last     = (state == ST_CRC) ? (bit_idx == 4'd15) : (bit_idx == 4'd7);
    // A sixth 1 turns the next bit time into a stuff 0; the field does not advance.
    assign stuff_due = serial && bit_end && stuff_ok && !stuff && cur_bit && (ones == 3'd5);
    assign adv       = serial && bit_end && !stuff_due;

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n   = state;
        pop       = 1'b0;
        crc_clr   = 1'b0;
        crc_en    = 1'b0;
        tx_status = 1'b0;
        se0       = 1'b0;
        case (state)
            ST_IDLE: begin
                if (tx_packet != TX_IDLE) begin
                    state_n = ST_SYNC;
                    crc_clr = 1'b1;
                end
            end
            ST_SYNC: if (adv && last) state_n = ST_PID;
            ST_PID: begin
                if (adv && last) begin
                    if (cmd != SEND_DATA)  state_n = ST_EOP_SE0;
                    else if (byte_cnt != 7'd0) begin
                        state_n = ST_DATA;
                        pop     = 1'b1;
                    end else               state_n = ST_CRC;
                end
            end
            ST_DATA: begin
                crc_en = adv;
                if (adv && last) begin
                    if (byte_cnt != 7'd0) pop = 1'b1;
                    else                  state_n = ST_CRC;
                end
            end
            ST_CRC:     if (adv && last) state_n = ST_EOP_SE0;
            ST_EOP_SE0: begin
                se0 = 1'b1;
                if (bit_end && bit_idx == 4'd1) state_n = ST_EOP_J;
            end
            ST_EOP_J:   if (bit_end) state_n = ST_DONE;
            ST_DONE: begin
                tx_status = 1'b1;
                state_n   = ST_IDLE;
            end
            default:    state_n = ST_IDLE;
        endcase
    end

    assign line_j             = serial ? (cur_bit ? lvl : ~lvl) : 1'b1;
    assign dplus_out          = se0 ? 1'b0 : line_j;
    assign dminus_out         = se0 ? 1'b0 : ~line_j;
    assign get_tx_packet_data = pop;
    assign tx_busy            = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            clk_cnt  <= '0;
            bit_idx  <= 4'd0;
            shifter  <= 8'h00;
            byte_cnt <= 7'd0;
            cmd      <= TX_IDLE;
            ones     <= 3'd0;
            stuff    <= 1'b0;
            lvl      <= 1'b1;
        end else if (state == ST_IDLE) begin
            clk_cnt <= '0;
            bit_idx <= 4'd0;
            ones    <= 3'd0;
            stuff   <= 1'b0;
            lvl     <= 1'b1;
            shifter <= SYNC_BYTE;
            if (tx_packet != TX_IDLE) begin
                cmd      <= tx_packet;
                byte_cnt <= (buffer_occupancy > MAX_PAYLOAD) ? MAX_PAYLOAD : buffer_occupancy;
            end
        end else begin
            clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
            if (serial && bit_end) begin
                lvl <= line_j;
                if (stuff_due) begin
                    stuff <= 1'b1;
                    ones  <= 3'd0;
                end else begin
                    stuff   <= 1'b0;
                    ones    <= cur_bit ? ones + 3'd1 : 3'd0;
                    bit_idx <= last ? 4'd0 : bit_idx + 4'd1;
                    if (pop) begin
                        shifter  <= tx_packet_data;
                        byte_cnt <= byte_cnt - 7'd1;
                    end else if (state == ST_SYNC && last) begin
                        shifter <= pid_byte;
                    end else begin
                        shifter <= shifter >> 1;
                    end
                end
            end else if (state == ST_EOP_SE0 && bit_end) begin
                bit_idx <= bit_idx + 4'd1;
            end
        end
    end

    usb_crc16_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clr    (crc_clr),
        .en     (crc_en),
        .bit_in (shifter[0]),
        .crc    (crc)
    );

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Directed bench: captures the line, NRZI-decodes and destuffs, checks PID/payload/CRC/EOP timing.
module tb_usb_tx_encoder;
    import usb_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [1:0] tx_packet = 2'b00;
    logic [6:0] buffer_occupancy = 7'd0;
    logic [7:0] tx_packet_data;
    logic       get_tx_packet_data, dplus_out, dminus_out, tx_status, tx_busy;

    always #5 clk = ~clk;

    usb_tx_encoder #(.CLKS_PER_BIT(4)) dut (
        .clk                (clk),
        .rst                (rst),
        .tx_packet          (tx_packet),
        .buffer_occupancy   (buffer_occupancy),
        .tx_packet_data     (tx_packet_data),
        .get_tx_packet_data (get_tx_packet_data),
        .dplus_out          (dplus_out),
        .dminus_out         (dminus_out),
        .tx_status          (tx_status),
        .tx_busy            (tx_busy)
    );

    // Show-ahead data buffer model
    logic [7:0] pay [64];
    logic [6:0] rd;
    logic       buf_clr = 1'b0;
    always @(posedge clk) begin
        if (buf_clr) rd <= 7'd0;
        else if (get_tx_packet_data) rd <= rd + 7'd1;
    end
    assign tx_packet_data = pay[rd[5:0]];

    int passed = 0, total = 0, fails = 0;
    bit exp_tog = 1'b0;

    logic [1:0] smp[$];
    bit         raw[$];
    bit         db[$];
    logic [7:0] rx_bytes[$];
    logic [7:0] rx_sync, rx_pid;
    int n_status, status_cyc, n_pops, se0_n, j_n, stuff_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        assert (obs === expv) begin
            passed++;
        end else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [7:0] exp_pid();
`ifdef USB_TX_DATA_TOGGLE_EN
        return exp_tog ? 8'h4B : 8'hC3;
`else
        return 8'hC3;
`endif
    endfunction

    function automatic logic [15:0] crc_model(input int n);
        logic [15:0] c = 16'hFFFF;
        for (int i = 0; i < n; i++)
            for (int j = 0; j < 8; j++)
                c = (c[0] ^ pay[i][j]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        return ~c;
    endfunction

    task automatic do_reset();
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        @(negedge clk); rst = 1'b0;
        exp_tog = 1'b0;
    endtask

    task automatic run_pkt(input logic [1:0] cmd, input logic [6:0] occ, input bit hold);
        int k, ones, i;
        logic [1:0] prev;
        logic [7:0] v;
        smp.delete(); raw.delete(); db.delete(); rx_bytes.delete();
        n_status = 0; status_cyc = 0; n_pops = 0; stuff_err = 0; se0_n = 0; j_n = 0;
        @(negedge clk); buf_clr = 1'b1;
        @(negedge clk); buf_clr = 1'b0; tx_packet = cmd; buffer_occupancy = occ;
        @(posedge clk);
        for (int c = 1; c <= 4000 && n_status == 0; c++) begin
            @(negedge clk);
            if (!hold) tx_packet = TX_IDLE;
            smp.push_back({dplus_out, dminus_out});
            n_pops += int'(get_tx_packet_data);
            if (tx_status) begin n_status++; status_cyc = c; end
        end
        prev = 2'b10; k = 0;
        while (4*k+1 < smp.size() && smp[4*k+1] != 2'b00) begin
            raw.push_back(smp[4*k+1] == prev);
            prev = smp[4*k+1];
            k++;
        end
        i = 4*k;
        while (i < smp.size() && smp[i] == 2'b00) begin se0_n++; i++; end
        while (i < smp.size()-1 && smp[i] == 2'b10) begin j_n++; i++; end
        ones = 0;
        foreach (raw[r]) begin
            if (ones == 6) begin
                if (raw[r]) stuff_err++;
                ones = 0;
            end else begin
                db.push_back(raw[r]);
                ones = raw[r] ? ones + 1 : 0;
            end
        end
        rx_sync = 8'hxx; rx_pid = 8'hxx;
        if (db.size() >= 16) begin
            for (int j = 0; j < 8; j++) begin
                rx_sync[j] = db[j];
                rx_pid[j]  = db[8+j];
            end
        end
        for (int b = 16; b + 8 <= db.size(); b += 8) begin
            for (int j = 0; j < 8; j++) v[j] = db[b+j];
            rx_bytes.push_back(v);
        end
    endtask

    task automatic chk_data(input string tag, input int n, input logic [15:0] exp_crc);
        int bad = 0;
        logic [15:0] got_crc = 16'hxxxx;
        chk({tag, "_status"}, n_status, 1);
        chk({tag, "_pid"}, rx_pid, exp_pid());
        chk({tag, "_pops"}, n_pops, n);
        chk({tag, "_len"}, rx_bytes.size(), n + 2);
        for (int i = 0; i < n && i < rx_bytes.size(); i++)
            if (rx_bytes[i] !== pay[i]) bad++;
        chk({tag, "_payload_bad"}, bad, 0);
        if (rx_bytes.size() >= 2)
            got_crc = {rx_bytes[rx_bytes.size()-1], rx_bytes[rx_bytes.size()-2]};
        chk({tag, "_crc"}, got_crc, exp_crc);
        chk({tag, "_se0"}, se0_n, 8);
        chk({tag, "_eopj"}, j_n, 4);
        exp_tog = ~exp_tog;
    endtask

    initial begin
        int pops_after, stat_after;
        foreach (pay[i]) pay[i] = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_dplus", dplus_out, 1);
        chk("rst_dminus", dminus_out, 0);
        chk("rst_busy", tx_busy, 0);
        chk("rst_status", tx_status, 0);
        chk("rst_pop", get_tx_packet_data, 0);
        rst = 1'b0;

        // ACK from idle
        run_pkt(SEND_ACK, 7'd0, 1'b0);
        chk("ack_sync", rx_sync, 8'h80);
        chk("ack_pid", rx_pid, 8'hD2);
        chk("ack_raw_bits", raw.size(), 16);
        chk("ack_status_n", n_status, 1);
        chk("ack_status_cyc", status_cyc, 77);
        chk("ack_pops", n_pops, 0);
        chk("ack_se0", se0_n, 8);
        chk("ack_eopj", j_n, 4);

        // NACK held through DONE
        run_pkt(SEND_NACK, 7'd0, 1'b1);
        chk("nack_pid", rx_pid, 8'h5A);
        chk("nack_status_n", n_status, 1);
        @(negedge clk);
        chk("nack_idle_after_done", tx_busy, 0);
        tx_packet = TX_IDLE;
        @(negedge clk);
        chk("nack_no_retx", tx_busy, 0);

        // Empty payload
        run_pkt(SEND_DATA, 7'd0, 1'b0);
        chk_data("occ0", 0, 16'h0000);

        // Single 0xFF: stuff after fourth payload 1; CRC of FF is FF00
        do_reset();
        pay[0] = 8'hFF;
        run_pkt(SEND_DATA, 7'd1, 1'b0);
        chk("ff_ones", {28'd0, raw[19], raw[18], raw[17], raw[16]}, 32'hF);
        chk("ff_stuff0", raw[20], 0);
        chk_data("ff", 1, 16'hFF00);

        // Full 64 random bytes, then occupancy 100 clamped to 64
        foreach (pay[i]) pay[i] = 8'($urandom);
        run_pkt(SEND_DATA, 7'd64, 1'b0);
        chk_data("p64", 64, crc_model(64));
        chk("p64_stuff_err", stuff_err, 0);
        run_pkt(SEND_DATA, 7'd100, 1'b0);
        chk_data("clamp", 64, crc_model(64));

        // Reset mid-DATA
        @(negedge clk); buf_clr = 1'b1;
        @(negedge clk); buf_clr = 1'b0; tx_packet = SEND_DATA; buffer_occupancy = 7'd10;
        @(posedge clk);
        n_pops = 0;
        repeat (100) begin
            @(negedge clk);
            tx_packet = TX_IDLE;
            n_pops += int'(get_tx_packet_data);
        end
        chk("abort_busy_before", tx_busy, 1);
        chk("abort_pops_before", n_pops > 0, 1);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_dplus", dplus_out, 1);
        chk("abort_dminus", dminus_out, 0);
        chk("abort_busy", tx_busy, 0);
        chk("abort_status", tx_status, 0);
        chk("abort_pop", get_tx_packet_data, 0);
        rst = 1'b0;
        exp_tog = 1'b0;
        pops_after = 0; stat_after = 0;
        repeat (300) begin
            @(negedge clk);
            pops_after += int'(get_tx_packet_data);
            stat_after += int'(tx_status);
        end
        chk("abort_pops_after", pops_after, 0);
        chk("abort_status_after", stat_after, 0);
        run_pkt(SEND_DATA, 7'd2, 1'b0);
        chk("abort_next_pid_data0", rx_pid, 8'hC3);
        chk_data("after_abort", 2, crc_model(2));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
